// File: rtl/fcore_sched_pkg.sv
// Shared types for the fCore issue scheduler: FSM state encoding and operand-mask bit positions.
// Pure declarations; no timing or backpressure behaviour of its own.
package fcore_sched_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_e;

  localparam int USE_A_BIT = 0;
  localparam int USE_B_BIT = 1;
  localparam int USE_C_BIT = 2;

endpackage

// File: rtl/fcore_issue_scheduler_if.sv
// Decode-to-scheduler issue handshake plus the writeback retire port.
// issue_valid/issue_ready handshake; master holds the instruction until issue_ready is seen high.
interface fcore_issue_scheduler_if #(
  parameter int REG_ADDR_WIDTH = 4
);

  logic                      issue_valid;
  logic                      issue_ready;
  logic [REG_ADDR_WIDTH-1:0] issue_dest;
  logic                      issue_writes;
  logic [REG_ADDR_WIDTH-1:0] issue_a;
  logic [REG_ADDR_WIDTH-1:0] issue_b;
  logic [REG_ADDR_WIDTH-1:0] issue_c;
  logic [2:0]                issue_uses;
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;

  modport master (
    output issue_valid, issue_dest, issue_writes, issue_a, issue_b, issue_c, issue_uses,
    output wb_valid, wb_addr,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_dest, issue_writes, issue_a, issue_b, issue_c, issue_uses,
    input  wb_valid, wb_addr,
    output issue_ready
  );

endinterface

// File: rtl/fcore_hazard_check.sv
// Combinational RAW/WAW/capacity hazard evaluator; zero latency, no state.
// FCORE_WB_BYPASS_EN: a register being written back this cycle is treated as clean.
module fcore_hazard_check
  import fcore_sched_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic [2**REG_ADDR_WIDTH-1:0] dirty,
  input  logic                         full,
  input  logic                         issue_writes,
  input  logic [REG_ADDR_WIDTH-1:0]    issue_dest,
  input  logic [REG_ADDR_WIDTH-1:0]    issue_a,
  input  logic [REG_ADDR_WIDTH-1:0]    issue_b,
  input  logic [REG_ADDR_WIDTH-1:0]    issue_c,
  input  logic [2:0]                   issue_uses,
  input  logic                         wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_addr,
  output logic                         hazard
);

  logic [2**REG_ADDR_WIDTH-1:0] busy;

`ifdef FCORE_WB_BYPASS_EN
  always_comb begin
    busy = dirty;
    if (wb_valid) busy[wb_addr] = 1'b0;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_addr};
  assign busy      = dirty;
`endif

  // Capacity check stays on the registered count even with bypass enabled.
  assign hazard = (issue_uses[USE_A_BIT] && busy[issue_a])
               || (issue_uses[USE_B_BIT] && busy[issue_b])
               || (issue_uses[USE_C_BIT] && busy[issue_c])
               || (issue_writes && (busy[issue_dest] || full));

endmodule

// File: rtl/fcore_issue_scheduler.sv
// Scoreboard issue scheduler: issue_ready is combinational, scoreboard/counters update one cycle after fire or writeback.
// Holds decode (issue_ready low) on RAW/WAW/full hazards and during flush drain; FCORE_WB_BYPASS_EN enables same-cycle wb bypass.
module fcore_issue_scheduler
  import fcore_sched_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 4,
  parameter int MAX_INFLIGHT    = 8,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  fcore_issue_scheduler_if.slave              io,
  input  logic                                flush,
  output logic [2**REG_ADDR_WIDTH-1:0]        dirty_registers,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_count,
  output logic                                stall,
  output logic [STALL_CNT_WIDTH-1:0]          stall_cycles,
  output logic                                wb_orphan
);

  localparam int NREG  = 2**REG_ADDR_WIDTH;
  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

  sched_state_e               state_q, state_d;
  logic [NREG-1:0]            dirty_q, dirty_d;
  logic [CNT_W-1:0]           inflight_q, inflight_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic                       wb_orphan_q, wb_orphan_d;
  logic                       full, hazard, fire, alloc, retire;

  assign full = (inflight_q == CNT_W'(MAX_INFLIGHT));

  fcore_hazard_check #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard (
    .dirty        (dirty_q),
    .full         (full),
    .issue_writes (io.issue_writes),
    .issue_dest   (io.issue_dest),
    .issue_a      (io.issue_a),
    .issue_b      (io.issue_b),
    .issue_c      (io.issue_c),
    .issue_uses   (io.issue_uses),
    .wb_valid     (io.wb_valid),
    .wb_addr      (io.wb_addr),
    .hazard       (hazard)
  );

  // STALL keeps issuing as soon as the hazard clears; only DRAIN blocks outright.
  assign io.issue_ready = (state_q != S_DRAIN) && !hazard;
  assign fire           = io.issue_valid && io.issue_ready;
  assign alloc          = fire && io.issue_writes;
  assign retire         = io.wb_valid && dirty_q[io.wb_addr];
  assign stall          = io.issue_valid && !io.issue_ready;

  always_comb begin
    dirty_d = dirty_q;
    if (retire) dirty_d[io.wb_addr] = 1'b0;
    if (alloc)  dirty_d[io.issue_dest] = 1'b1;

    inflight_d  = inflight_q + CNT_W'(alloc) - CNT_W'(retire);
    wb_orphan_d = wb_orphan_q | (io.wb_valid && !dirty_q[io.wb_addr]);

    stall_cycles_d = stall_cycles_q;
    if (stall && (state_q != S_DRAIN) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + STALL_CNT_WIDTH'(1);

    state_d = state_q;
    case (state_q)
      S_RUN:   if (io.issue_valid && hazard) state_d = S_STALL;
      S_STALL: if (!io.issue_valid || !hazard) state_d = S_RUN;
      // Exit on the retiring cycle so RUN is visible right after the last writeback.
      S_DRAIN: if (inflight_d == '0) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    if (flush) state_d = S_DRAIN;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_RUN;
      dirty_q        <= '0;
      inflight_q     <= '0;
      stall_cycles_q <= '0;
      wb_orphan_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      dirty_q        <= dirty_d;
      inflight_q     <= inflight_d;
      stall_cycles_q <= stall_cycles_d;
      wb_orphan_q    <= wb_orphan_d;
    end
  end

  assign dirty_registers = dirty_q;
  assign inflight_count  = inflight_q;
  assign stall_cycles    = stall_cycles_q;
  assign wb_orphan       = wb_orphan_q;

endmodule

// File: tb/tb_fcore_issue_scheduler.sv
// Self-checking bench for fcore_issue_scheduler: directed scenarios plus randomized traffic against a rule-level model.
module tb_fcore_issue_scheduler;

  localparam int RAW  = 4;
  localparam int NREG = 16;
  localparam int MAXF = 8;
  localparam int SCW  = 16;
  localparam int CW   = $clog2(MAXF+1);
  localparam int SMAX = (1 << SCW) - 1;
`ifdef FCORE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic [NREG-1:0] dirty_registers;
  logic [CW-1:0]   inflight_count;
  logic            stall;
  logic [SCW-1:0]  stall_cycles;
  logic            wb_orphan;

  fcore_issue_scheduler_if #(.REG_ADDR_WIDTH(RAW)) io ();

  fcore_issue_scheduler #(
    .REG_ADDR_WIDTH  (RAW),
    .MAX_INFLIGHT    (MAXF),
    .STALL_CNT_WIDTH (SCW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io              (io),
    .flush           (flush),
    .dirty_registers (dirty_registers),
    .inflight_count  (inflight_count),
    .stall           (stall),
    .stall_cycles    (stall_cycles),
    .wb_orphan       (wb_orphan)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: set of busy registers, outstanding count, stall tally, sticky orphan, draining flag.
  logic [NREG-1:0] m_dirty;
  int              m_inflight;
  int              m_stalls;
  bit              m_orphan;
  bit              m_drain;

  function automatic bit m_ready();
    logic [NREG-1:0] busy;
    busy = m_dirty;
    if (BYPASS && io.wb_valid) busy[io.wb_addr] = 1'b0;
    if (m_drain) return 1'b0;
    if (io.issue_uses[0] && busy[io.issue_a]) return 1'b0;
    if (io.issue_uses[1] && busy[io.issue_b]) return 1'b0;
    if (io.issue_uses[2] && busy[io.issue_c]) return 1'b0;
    if (io.issue_writes && (busy[io.issue_dest] || m_inflight == MAXF)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    bit rdy;
    rdy = m_ready();
    if (!reset) begin
      m_dirty = '0; m_inflight = 0; m_stalls = 0; m_orphan = 0; m_drain = 0;
    end else begin
      if (io.issue_valid && !rdy && !m_drain && m_stalls < SMAX) m_stalls++;
      if (io.wb_valid) begin
        if (m_dirty[io.wb_addr]) begin
          m_dirty[io.wb_addr] = 1'b0;
          m_inflight--;
        end else begin
          m_orphan = 1'b1;
        end
      end
      if (io.issue_valid && rdy && io.issue_writes) begin
        m_dirty[io.issue_dest] = 1'b1;
        m_inflight++;
      end
      if (flush) m_drain = 1'b1;
      else if (m_inflight == 0) m_drain = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_issue(input bit v, input bit w, input int d, input int a, input int b, input int c,
                           input logic [2:0] u);
    io.issue_valid  = v;
    io.issue_writes = w;
    io.issue_dest   = 4'(d);
    io.issue_a      = 4'(a);
    io.issue_b      = 4'(b);
    io.issue_c      = 4'(c);
    io.issue_uses   = u;
  endtask

  task automatic set_wb(input bit v, input int addr);
    io.wb_valid = v;
    io.wb_addr  = 4'(addr);
  endtask

  task automatic clear_inputs();
    set_issue(0, 0, 0, 0, 0, 0, 3'b000);
    set_wb(0, 0);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    set_issue(1, 1, 6, 0, 0, 0, 3'b000);
    #1;
    tests_run++; if (dirty_registers !== '0) begin tests_failed++; $display("FAIL reset_dirty: got %h want 0", dirty_registers); end
    tests_run++; if (inflight_count !== '0) begin tests_failed++; $display("FAIL reset_inflight: got %0d want 0", inflight_count); end
    tests_run++; if (stall_cycles !== '0) begin tests_failed++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
    tests_run++; if (wb_orphan !== 1'b0) begin tests_failed++; $display("FAIL reset_orphan: got %b want 0", wb_orphan); end
    tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", io.issue_ready); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
    clear_inputs();
  endtask

  task automatic test_raw();
    do_reset();
    set_issue(1, 1, 3, 0, 0, 0, 3'b000);
    #1;
    tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_producer_ready: got %b want 1", io.issue_ready); end
    tick();
    set_issue(1, 1, 4, 3, 0, 0, 3'b001);
    #1;
    tests_run++; if (dirty_registers[3] !== 1'b1) begin tests_failed++; $display("FAIL raw_dirty3: got %b want 1", dirty_registers[3]); end
    tests_run++; if (io.issue_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_blocked: got %b want 0", io.issue_ready); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL raw_stall: got %b want 1", stall); end
    tick();
    tests_run++; if (io.issue_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_hold: got %b want 0", io.issue_ready); end
    set_wb(1, 3);
    #1;
    tests_run++; if (io.issue_ready !== BYPASS) begin tests_failed++; $display("FAIL raw_wb_cycle_ready: got %b want %b", io.issue_ready, BYPASS); end
    tick();
    set_wb(0, 0);
    #1;
    tests_run++; if (dirty_registers[4] !== BYPASS) begin tests_failed++; $display("FAIL raw_issued_in_wb_cycle: got %b want %b", dirty_registers[4], BYPASS); end
    tests_run++; if (io.issue_ready !== !BYPASS) begin tests_failed++; $display("FAIL raw_ready_after_wb: got %b want %b", io.issue_ready, !BYPASS); end
    tick();
    clear_inputs();
    #1;
    tests_run++; if (dirty_registers !== 16'h0010) begin tests_failed++; $display("FAIL raw_final_dirty: got %h want 0010", dirty_registers); end
    tests_run++; if (stall_cycles !== SCW'(m_stalls)) begin tests_failed++; $display("FAIL raw_stall_cycles: got %0d want %0d", stall_cycles, m_stalls); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= MAXF; i++) begin
      set_issue(1, 1, i, 0, 0, 0, 3'b000);
      #1;
      tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL full_fill_%0d: got %b want 1", i, io.issue_ready); end
      tick();
    end
    set_issue(1, 1, 9, 0, 0, 0, 3'b000);
    #1;
    tests_run++; if (io.issue_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ninth_blocked: got %b want 0", io.issue_ready); end
    tests_run++; if (inflight_count !== CW'(8)) begin tests_failed++; $display("FAIL full_inflight8: got %0d want 8", inflight_count); end
    set_wb(1, 1);
    #1;
    tests_run++; if (io.issue_ready !== 1'b0) begin tests_failed++; $display("FAIL full_wb_cycle: got %b want 0", io.issue_ready); end
    tick();
    set_wb(0, 0);
    #1;
    tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL full_after_wb: got %b want 1", io.issue_ready); end
    tests_run++; if (inflight_count !== CW'(7)) begin tests_failed++; $display("FAIL full_inflight7: got %0d want 7", inflight_count); end
    tick();
    clear_inputs();
    #1;
    tests_run++; if (dirty_registers !== 16'h03FC) begin tests_failed++; $display("FAIL full_final_dirty: got %h want 03fc", dirty_registers); end
  endtask

  task automatic test_same_cycle();
    int exp_cnt;
    do_reset();
    set_issue(1, 1, 5, 0, 0, 0, 3'b000);
    tick();
    set_issue(1, 1, 5, 0, 0, 0, 3'b000);
    set_wb(1, 5);
    #1;
    tests_run++; if (io.issue_ready !== BYPASS) begin tests_failed++; $display("FAIL same_ready: got %b want %b", io.issue_ready, BYPASS); end
    tick();
    clear_inputs();
    exp_cnt = BYPASS ? 1 : 0;
    #1;
    tests_run++; if (dirty_registers[5] !== BYPASS) begin tests_failed++; $display("FAIL same_dirty5: got %b want %b", dirty_registers[5], BYPASS); end
    tests_run++; if (inflight_count !== CW'(exp_cnt)) begin tests_failed++; $display("FAIL same_inflight: got %0d want %0d", inflight_count, exp_cnt); end
  endtask

  task automatic test_orphan();
    do_reset();
    set_issue(1, 1, 2, 0, 0, 0, 3'b000);
    tick();
    clear_inputs();
    set_wb(1, 7);
    tick();
    set_wb(0, 0);
    #1;
    tests_run++; if (wb_orphan !== 1'b1) begin tests_failed++; $display("FAIL orphan_set: got %b want 1", wb_orphan); end
    tests_run++; if (dirty_registers !== 16'h0004) begin tests_failed++; $display("FAIL orphan_dirty: got %h want 0004", dirty_registers); end
    tests_run++; if (inflight_count !== CW'(1)) begin tests_failed++; $display("FAIL orphan_inflight: got %0d want 1", inflight_count); end
    repeat (3) tick();
    tests_run++; if (wb_orphan !== 1'b1) begin tests_failed++; $display("FAIL orphan_sticky: got %b want 1", wb_orphan); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 10; r <= 12; r++) begin
      set_issue(1, 1, r, 0, 0, 0, 3'b000);
      tick();
    end
    clear_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_issue(1, 0, 0, 0, 0, 0, 3'b000);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++; if (io.issue_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_%0d: got %b want 0", k, io.issue_ready); end
      tick();
      set_wb(1, 10 + k);
      #1;
      tests_run++; if (io.issue_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_wb_%0d: got %b want 0", k, io.issue_ready); end
      tick();
      set_wb(0, 0);
    end
    #1;
    tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_run_after: got %b want 1", io.issue_ready); end
    tests_run++; if (dirty_registers !== '0) begin tests_failed++; $display("FAIL flush_dirty: got %h want 0", dirty_registers); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    tests_run++; if (io.issue_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_empty_drain: got %b want 0", io.issue_ready); end
    tick();
    tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_empty_exit: got %b want 1", io.issue_ready); end
    clear_inputs();
  endtask

  task automatic test_reset_drain();
    do_reset();
    set_issue(1, 1, 9, 0, 0, 0, 3'b000);
    tick();
    set_issue(1, 0, 0, 0, 0, 0, 3'b000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_reset_ready: got %b want 1", io.issue_ready); end
    tests_run++; if (dirty_registers !== '0) begin tests_failed++; $display("FAIL drain_reset_dirty: got %h want 0", dirty_registers); end
    clear_inputs();
  endtask

  task automatic test_random();
    int q[$];
    bit exp_rdy;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 49) == 0);
      set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 3'($urandom_range(0, 7)));
      q.delete();
      for (int i = 0; i < NREG; i++) if (m_dirty[i]) q.push_back(i);
      if (q.size() != 0 && $urandom_range(0, 3) != 0)
        set_wb($urandom_range(0, 2) != 0, q[$urandom_range(0, q.size() - 1)]);
      else
        set_wb($urandom_range(0, 2) == 0, $urandom_range(0, 7));
      #1;
      exp_rdy = m_ready();
      tests_run++; if (io.issue_ready !== exp_rdy) begin tests_failed++; $display("FAIL rnd_ready@%0d: got %b want %b", n, io.issue_ready, exp_rdy); end
      tests_run++; if (stall !== (io.issue_valid && !exp_rdy)) begin tests_failed++; $display("FAIL rnd_stall@%0d: got %b want %b", n, stall, io.issue_valid && !exp_rdy); end
      tests_run++; if (dirty_registers !== m_dirty) begin tests_failed++; $display("FAIL rnd_dirty@%0d: got %h want %h", n, dirty_registers, m_dirty); end
      tests_run++; if (inflight_count !== CW'(m_inflight)) begin tests_failed++; $display("FAIL rnd_inflight@%0d: got %0d want %0d", n, inflight_count, m_inflight); end
      tests_run++; if (stall_cycles !== SCW'(m_stalls)) begin tests_failed++; $display("FAIL rnd_stall_cycles@%0d: got %0d want %0d", n, stall_cycles, m_stalls); end
      tests_run++; if (wb_orphan !== m_orphan) begin tests_failed++; $display("FAIL rnd_orphan@%0d: got %b want %b", n, wb_orphan, m_orphan); end
      tick();
    end
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    set_issue(1, 1, 2, 0, 0, 0, 3'b000);
    tick();
    set_issue(1, 0, 0, 2, 0, 0, 3'b001);
    repeat (70000) tick();
    tests_run++; if (stall_cycles !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_count: got %h want ffff", stall_cycles); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL sat_stall: got %b want 1", stall); end
    reset = 1'b0;
    tick();
    tests_run++; if (stall_cycles !== '0) begin tests_failed++; $display("FAIL sat_reset_count: got %h want 0", stall_cycles); end
    tests_run++; if (dirty_registers !== '0) begin tests_failed++; $display("FAIL sat_reset_dirty: got %h want 0", dirty_registers); end
    tests_run++; if (inflight_count !== '0) begin tests_failed++; $display("FAIL sat_reset_inflight: got %0d want 0", inflight_count); end
    tests_run++; if (wb_orphan !== 1'b0) begin tests_failed++; $display("FAIL sat_reset_orphan: got %b want 0", wb_orphan); end
    tests_run++; if (io.issue_ready !== 1'b1) begin tests_failed++; $display("FAIL sat_reset_ready: got %b want 1", io.issue_ready); end
    reset = 1'b1;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    m_dirty = '0; m_inflight = 0; m_stalls = 0; m_orphan = 0; m_drain = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_raw();
    test_full();
    test_same_cycle();
    test_orphan();
    test_flush();
    test_reset_drain();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
